// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 mode constants, sync polarities and a line/frame total helper
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;
    localparam int DEF_WIN_X0   = 80;
    localparam int DEF_WIN_X1   = 560;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping position counter with registered sync-region decode of the next position
module vga_axis_counter #(
    parameter int   TOTAL      = 800,
    parameter int   SYNC_START = 656,
    parameter int   SYNC_LEN   = 96,
    parameter logic POL        = 1'b0,
    parameter int   CW         = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          step,
    output logic [CW-1:0] pos,
    output logic [CW-1:0] nxt,
    output logic          wrap,
    output logic          sync
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SS   = CW'(SYNC_START);
    localparam logic [CW-1:0] SE   = CW'(SYNC_START + SYNC_LEN);

    // next position: wrap from the last count back to zero
    always_comb begin
        wrap = pos == LAST;
        nxt  = wrap ? '0 : pos + CW'(1);
    end

    // position and sync are updated together so sync never lags the coordinate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos  <= LAST;
            sync <= ~POL;
        end else if (step) begin
            pos  <= nxt;
            sync <= (nxt >= SS && nxt < SE) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator; optional horizontal window via VGA_TIMING_WINDOW_EN
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = POL_LOW,
    parameter logic VS_POL   = POL_LOW,
    parameter int   CW       = DEF_CW,
    parameter int   WIN_X0   = DEF_WIN_X0,
    parameter int   WIN_X1   = DEF_WIN_X1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          video_active,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          win_active,
    output logic [CW-1:0] win_x
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL - 1 >= (1 << CW) || V_TOTAL - 1 >= (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL-1 or V_TOTAL-1");
    end
    if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    logic [CW-1:0] h_nxt, v_nxt, y_n;
    logic          h_wrap, v_wrap, act_n;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .POL(HS_POL), .CW(CW)
    ) u_h (
        .clk(clk), .reset_n(reset_n), .step(pix_ce),
        .pos(pixel_x), .nxt(h_nxt), .wrap(h_wrap), .sync(hsync)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .POL(VS_POL), .CW(CW)
    ) u_v (
        .clk(clk), .reset_n(reset_n), .step(pix_ce & h_wrap),
        .pos(pixel_y), .nxt(v_nxt), .wrap(v_wrap), .sync(vsync)
    );

    // line the next position will be on, so active decode lands with the coordinates
    always_comb begin
        y_n   = h_wrap ? v_nxt : pixel_y;
        act_n = h_nxt < CW'(H_ACTIVE) && y_n < CW'(V_ACTIVE);
    end

    // strobes last one clk per advancing edge; active level holds while pix_ce is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_active <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            line_start  <= pix_ce & h_wrap;
            frame_start <= pix_ce & h_wrap & v_wrap;
            if (pix_ce) video_active <= act_n;
        end
    end

`ifdef VGA_TIMING_WINDOW_EN
    if (!(WIN_X0 >= 0 && WIN_X0 < WIN_X1 && WIN_X1 <= H_ACTIVE)) begin : g_bad_win
        $error("vga_timing_gen: window needs 0 <= WIN_X0 < WIN_X1 <= H_ACTIVE");
    end

    localparam logic [CW-1:0] WX0 = CW'(WIN_X0);
    localparam logic [CW-1:0] WX1 = CW'(WIN_X1);

    logic win_n;

    always_comb win_n = act_n && h_nxt >= WX0 && h_nxt < WX1;

    // window flag and window-relative x, zero outside the window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_active <= 1'b0;
            win_x      <= '0;
        end else if (pix_ce) begin
            win_active <= win_n;
            win_x      <= win_n ? h_nxt - WX0 : '0;
        end
    end
`else
    if (WIN_X0 < 0 || WIN_X1 < 0) begin : g_bad_win
        $error("vga_timing_gen: window bounds must be non-negative");
    end

    assign win_active = video_active;
    assign win_x      = pixel_x;
`endif

endmodule
